// File: rtl/seg7_pkg.sv
// Shared types and glyph data for the MM.SS seven-segment display stage.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CONV_MIN = 2'd1,
    ST_CONV_SEC = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  // Active-low cathode patterns, bit order g..a.
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Map one BCD digit to its cathode pattern; non-decimal codes show blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/bin6_to_bcd.sv
// Sequential double-dabble converter: 6-bit binary to two BCD digits.
// The start edge already performs the first shift, so the result is final
// after six edges and done pulses for one cycle right after that.
module bin6_to_bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] bin,
  output logic [7:0] bcd,
  output logic       done
);

  logic [4:0] shift_r;
  logic [2:0] cnt_r;
  logic [7:0] bcd_r;
  logic       done_r;

  // One add-3-then-shift step over both BCD nibbles.
  function automatic logic [7:0] dabble_step(input logic [7:0] acc, input logic bit_in);
    logic [7:0] adj;
    adj = acc;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    else                  adj[3:0] = adj[3:0];
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    else                  adj[7:4] = adj[7:4];
    return {adj[6:0], bit_in};
  endfunction

  // Load-and-first-step on start, then five further steps, then flag done.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= 5'd0;
      cnt_r   <= 3'd0;
      bcd_r   <= 8'd0;
      done_r  <= 1'b0;
    end else if (start) begin
      bcd_r   <= dabble_step(8'd0, bin[5]);
      shift_r <= bin[4:0];
      cnt_r   <= 3'd5;
      done_r  <= 1'b0;
    end else if (cnt_r != 3'd0) begin
      bcd_r   <= dabble_step(bcd_r, shift_r[4]);
      shift_r <= {shift_r[3:0], 1'b0};
      cnt_r   <= cnt_r - 3'd1;
      done_r  <= (cnt_r == 3'd1);
    end else begin
      done_r  <= 1'b0;
    end
  end

  assign bcd  = bcd_r;
  assign done = done_r;

endmodule

// File: rtl/seg7_time_display.sv
// MM.SS display stage: captures min/sec on change, converts both to BCD with
// one shared converter, commits all four digits at once and scans them out.
// Optional feature macro: SEG7_BLINK_EN (blank the anodes periodically while
// done_in is high).
module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       done_in,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  state_t     state_r;
  logic [5:0] min_cap_r, sec_cap_r;
  logic [7:0] min_bcd_r;
  logic [15:0] dig_r;        // {min tens, min ones, sec tens, sec ones}
  logic       busy_r;
  logic       change_s;
  logic       conv_start_s;
  logic [5:0] conv_bin_s;
  logic [7:0] conv_bcd_s;
  logic       conv_done_s;
  logic [SW-1:0] presc_r;
  digit_idx_t idx_r;
  logic [3:0] scan_digit_s;
  logic [3:0] scan_an_s;
  logic       scan_dp_s;
  logic       blank_s;
  logic [7:0] seg_r;
  logic [3:0] an_r;

  assign change_s = ({min_in, sec_in} != {min_cap_r, sec_cap_r});

  // Kick the converter: minutes straight from the inputs on the capture edge,
  // seconds from the captured value the moment minutes finish.
  always_comb begin
    conv_start_s = 1'b0;
    conv_bin_s   = min_in;
    case (state_r)
      ST_IDLE: begin
        conv_start_s = change_s;
        conv_bin_s   = min_in;
      end
      ST_CONV_MIN: begin
        conv_start_s = conv_done_s;
        conv_bin_s   = sec_cap_r;
      end
      default: begin
        conv_start_s = 1'b0;
        conv_bin_s   = sec_cap_r;
      end
    endcase
  end

  bin6_to_bcd u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start_s),
    .bin   (conv_bin_s),
    .bcd   (conv_bcd_s),
    .done  (conv_done_s)
  );

  // Capture/convert/commit sequencer; digits change only in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      min_cap_r <= 6'd0;
      sec_cap_r <= 6'd0;
      min_bcd_r <= 8'd0;
      dig_r     <= 16'd0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (change_s) begin
            min_cap_r <= min_in;
            sec_cap_r <= sec_in;
            busy_r    <= 1'b1;
            state_r   <= ST_CONV_MIN;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_CONV_MIN: begin
          if (conv_done_s) begin
            min_bcd_r <= conv_bcd_s;
            state_r   <= ST_CONV_SEC;
          end
        end
        ST_CONV_SEC: begin
          if (conv_done_s) state_r <= ST_COMMIT;
        end
        ST_COMMIT: begin
          dig_r   <= {min_bcd_r, conv_bcd_s};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Digit-slot prescaler and scan index.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
      idx_r   <= 2'd0;
    end else if (presc_r == SCAN_MAX) begin
      presc_r <= '0;
      idx_r   <= idx_r + 2'd1;
    end else begin
      presc_r <= presc_r + SW'(1);
    end
  end

  // Select the digit, anode and decimal point for the current slot.
  always_comb begin
    scan_digit_s = dig_r[3:0];
    case (idx_r)
      2'd0:    scan_digit_s = dig_r[3:0];
      2'd1:    scan_digit_s = dig_r[7:4];
      2'd2:    scan_digit_s = dig_r[11:8];
      2'd3:    scan_digit_s = dig_r[15:12];
      default: scan_digit_s = 4'd0;
    endcase
    scan_an_s = ~(4'b0001 << idx_r);
    if (idx_r == 2'd2) scan_dp_s = 1'b0;
    else               scan_dp_s = 1'b1;
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_r;
  logic          blink_off_r;

  // Blink phase: toggles every BLINK_DIV cycles while done_in is held.
  always_ff @(posedge clk) begin
    if (reset || !done_in) begin
      blink_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_MAX) begin
      blink_cnt_r <= '0;
      blink_off_r <= ~blink_off_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
    end
  end

  assign blank_s = blink_off_r;
`else
  localparam int blink_div_unused = BLINK_DIV;
  logic done_in_unused_s;
  assign done_in_unused_s = done_in;
  assign blank_s = 1'b0;
`endif

  // Registered drive of cathodes and anodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= SEG_OFF;
      an_r  <= AN_OFF;
    end else begin
      seg_r <= {scan_dp_s, bcd_to_seg(scan_digit_s)};
      an_r  <= blank_s ? AN_OFF : scan_an_s;
    end
  end

  assign seg  = seg_r;
  assign an   = an_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_seg7_time_display.sv
// Directed bench for seg7_time_display with SCAN_DIV=4, BLINK_DIV=8.
`timescale 1ns/1ps
module tb_seg7_time_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] min_in, sec_in;
  logic       done_in;
  logic [7:0] seg;
  logic [3:0] an;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_time_display #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .min_in  (min_in),
    .sec_in  (sec_in),
    .done_in (done_in),
    .seg     (seg),
    .an      (an),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for busy to rise, then count the samples it stays high.
  task automatic run_conv(output int len);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) break;
    end
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    len = n;
  endtask

  // Wait for a given anode slot, then check anode and cathodes.
  task automatic wait_an(input string tag, input logic [3:0] an_exp, input logic [7:0] seg_exp);
    for (int i = 0; i < 20; i++) begin
      if (an === an_exp) break;
      @(negedge clk);
    end
    chk({tag, "_an"}, an, an_exp);
    chk({tag, "_seg"}, seg, seg_exp);
  endtask

  initial begin
    int len;
    int win [4];
    int blanks;

    // 1: reset state and first scan slot
    reset = 1'b1; min_in = 6'd0; sec_in = 6'd0; done_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("slot0_an", an, 4'hE);
    chk("slot0_seg", seg, 8'hC0);
    repeat (6) @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // 2: 12:34
    min_in = 6'd12; sec_in = 6'd34;
    run_conv(len);
    chk("len_1234", len, 13);
    chk("dig_1234", dut.dig_r, 16'h1234);
    @(negedge clk);
    wait_an("s1234_0", 4'hE, 8'h99);
    wait_an("s1234_1", 4'hD, 8'hB0);
    wait_an("s1234_2", 4'hB, 8'h24);
    wait_an("s1234_3", 4'h7, 8'hF9);

    // 3: 63:63 upper bound
    min_in = 6'd63; sec_in = 6'd63;
    run_conv(len);
    chk("len_6363", len, 13);
    chk("dig_6363", dut.dig_r, 16'h6363);
    @(negedge clk);
    wait_an("s6363_0", 4'hE, 8'hB0);
    wait_an("s6363_1", 4'hD, 8'h82);
    wait_an("s6363_2", 4'hB, 8'h30);
    wait_an("s6363_3", 4'h7, 8'h82);

    // 4: change during conversion is deferred to the next IDLE compare
    min_in = 6'd5; sec_in = 6'd10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) break;
    end
    chk("chg_rise", busy, 1'b1);
    repeat (4) @(negedge clk);
    sec_in = 6'd11;
    repeat (8) @(negedge clk);
    chk("chg_b13", busy, 1'b1);
    chk("chg_pre_dig", dut.dig_r, 16'h6363);
    @(negedge clk);
    chk("chg_idle", busy, 1'b0);
    chk("chg_dig10", dut.dig_r, 16'h0510);
    @(negedge clk);
    chk("chg_rerise", busy, 1'b1);
    repeat (6) @(negedge clk);
    chk("chg_mid_dig", dut.dig_r, 16'h0510);
    repeat (6) @(negedge clk);
    chk("chg_b13b", busy, 1'b1);
    @(negedge clk);
    chk("chg_idle2", busy, 1'b0);
    chk("chg_dig11", dut.dig_r, 16'h0511);
    @(negedge clk);
    wait_an("s0511_0", 4'hE, 8'hF9);

    // 5: reset during CONV_SEC, then full re-conversion
    min_in = 6'd7; sec_in = 6'd45;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) break;
    end
    repeat (7) @(negedge clk);
    chk("rs_state", dut.state_r, 2'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_an", an, 4'hF);
    chk("rs_seg", seg, 8'hFF);
    chk("rs_busy", busy, 1'b0);
    chk("rs_dig", dut.dig_r, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    run_conv(len);
    chk("len_0745", len, 13);
    chk("dig_0745", dut.dig_r, 16'h0745);
    @(negedge clk);
    wait_an("s0745_3", 4'h7, 8'hC0);
    wait_an("s0745_2", 4'hB, 8'h78);
    wait_an("s0745_1", 4'hD, 8'h99);
    wait_an("s0745_0", 4'hE, 8'h92);

    // 6: blink behaviour on done_in
    win = '{0, 0, 0, 0};
    done_in = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (an === 4'hF) win[i / 8]++;
    end
`ifdef SEG7_BLINK_EN
    chk("blink_w0", win[0], 0);
    chk("blink_w1", win[1], 8);
    chk("blink_w2", win[2], 0);
    chk("blink_w3", win[3], 8);
`else
    chk("noblink", win[0] + win[1] + win[2] + win[3], 0);
`endif
    done_in = 1'b0;
    repeat (2) @(negedge clk);
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an === 4'hF) blanks++;
    end
    chk("steady", blanks, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
